i2c_driver: RTL and testbench

- Single-master I2C byte-transaction engine for a 24xx-style EEPROM.
- A one-shot command runs one complete bus transaction and reports completion and acknowledge status:
  - write: one data byte to an 8- or 16-bit memory address;
  - read: one data byte from an 8- or 16-bit memory address.
- Sits between user control logic and the board SCL/SDA pins. It also exports a divided drive clock for user logic.

---
 rtl/i2c_driver.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2c_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_driver.sv
// i2c_driver: single-master I2C engine that runs one EEPROM byte write or
// byte read per command. It supports 8- and 16-bit memory addresses and
// reports completion and the combined slave acknowledge status.
`timescale 1ns/1ps
module i2c_driver #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
   parameter int         CLK_FREQ   = 50_000_000,
   parameter int         I2C_FREQ   = 250_000
) (
   input  logic        clk,
   input  logic        rst_n,       // active-high synchronous reset (1 = reset)
   input  logic        bit_ctrl,
   input  logic [15:0] i2c_addr,
   input  logic [7:0]  i2c_data_w,
   input  logic        i2c_exec,
   input  logic        i2c_rh_wl,
   output logic        dri_clk,
   output logic        scl,
   output logic        i2c_ack,
   output logic [7:0]  i2c_data_r,
   output logic        i2c_done,
   inout  wire         sda
);

   localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SLADDR, ST_ADDR16, ST_ADDR8,
      ST_DATA_WR, ST_ADDR_RD, ST_DATA_RD, ST_STOP
   } state_t;

   logic [CW-1:0] div_cnt_r;
   logic          dri_clk_r;
   logic          tick_s;

   state_t        state_r, state_nx;
   logic [5:0]    cnt_r, cnt_nx;
   logic          scl_r, scl_nx;
   logic          sda_oe_r, sda_oe_nx;
   logic          done_r, done_nx;

   logic          pend_r;
   logic          bit_ctrl_r;
   logic [15:0]   addr_r;
   logic [7:0]    wdata_r;
   logic          rh_wl_r;
   logic          ack_r;
   logic [7:0]    rx_sh_r;
   logic [7:0]    data_r_r;

   logic          accept_s, ack_smp_s, rx_smp_s, rx_commit_s;
   logic [7:0]    tx_byte_s;
   logic [5:0]    pre_len_s;
   logic [5:0]    j_s;
   logic [3:0]    slot_s;
   logic [1:0]    ph_s;
   logic          in_byte_s, byte_last_s, tx_en_s, tx_bit_s;

   assign tick_s      = (div_cnt_r == DIV_LAST);
   assign dri_clk     = dri_clk_r;
   assign scl         = scl_r;
   assign i2c_ack     = ack_r;
   assign i2c_data_r  = data_r_r;
   assign i2c_done    = done_r;
   assign sda         = sda_oe_r ? 1'b0 : 1'bz;

   // Tick divider: one tick per quarter SCL bit, dri_clk toggles twice per tick period
   always_ff @(posedge clk) begin
      if (rst_n) begin
         div_cnt_r <= {CW{1'b0}};
         dri_clk_r <= 1'b0;
      end else begin
         if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {CW{1'b0}};
         end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
         end
         if ((div_cnt_r == DIV_LAST) || (div_cnt_r == HALF_LAST)) begin
            dri_clk_r <= ~dri_clk_r;
         end else begin
            dri_clk_r <= dri_clk_r;
         end
      end
   end

   // Byte framing: which byte is shifted in the current state and where the bit slots start
   always_comb begin
      tx_byte_s = 8'hFF;
      pre_len_s = 6'd0;
      case (state_r)
         ST_SLADDR: begin
            tx_byte_s = {SLAVE_ADDR, 1'b0};
            pre_len_s = 6'd1;              // START tick before the first bit
         end
         ST_ADDR16:  tx_byte_s = addr_r[15:8];
         ST_ADDR8:   tx_byte_s = addr_r[7:0];
         ST_DATA_WR: tx_byte_s = wdata_r;
         ST_ADDR_RD: begin
            tx_byte_s = {SLAVE_ADDR, 1'b1};
            pre_len_s = 6'd3;              // repeated START takes three ticks
         end
         default: begin
            tx_byte_s = 8'hFF;
            pre_len_s = 6'd0;
         end
      endcase
   end

   assign tx_en_s     = (state_r != ST_DATA_RD);
   assign in_byte_s   = (cnt_r >= pre_len_s);
   assign j_s         = cnt_r - pre_len_s;
   assign slot_s      = j_s[5:2];          // 0..7 data bits, 8 = ACK slot
   assign ph_s        = j_s[1:0];          // t0..t3 inside a bit
   assign byte_last_s = in_byte_s && (j_s == 6'd35);
   assign tx_bit_s    = tx_byte_s[3'd7 - slot_s[2:0]];

   // FSM next state and next bus pin levels, advanced once per tick
   always_comb begin
      state_nx    = state_r;
      cnt_nx      = cnt_r;
      scl_nx      = scl_r;
      sda_oe_nx   = sda_oe_r;
      done_nx     = 1'b0;
      accept_s    = 1'b0;
      ack_smp_s   = 1'b0;
      rx_smp_s    = 1'b0;
      rx_commit_s = 1'b0;
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               scl_nx    = 1'b1;
               sda_oe_nx = 1'b0;
               if (pend_r) begin
                  accept_s = 1'b1;
                  state_nx = ST_SLADDR;
                  cnt_nx   = 6'd0;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_STOP: begin
               case (cnt_r[1:0])
                  2'd0: begin
                     scl_nx    = 1'b0;
                     sda_oe_nx = 1'b1;
                     cnt_nx    = 6'd1;
                  end
                  2'd1: begin
                     scl_nx = 1'b1;
                     cnt_nx = 6'd2;
                  end
                  default: begin
                     sda_oe_nx = 1'b0;     // SDA rises while SCL high
                     done_nx   = 1'b1;
                     cnt_nx    = 6'd0;
                     state_nx  = ST_IDLE;
                  end
               endcase
            end
            default: begin
               if (!in_byte_s) begin
                  cnt_nx = cnt_r + 6'd1;
                  if (state_r == ST_SLADDR) begin
                     sda_oe_nx = 1'b1;     // START: SDA falls with SCL high
                  end else begin
                     case (cnt_r[1:0])
                        2'd0: begin
                           scl_nx    = 1'b0;
                           sda_oe_nx = 1'b0;
                        end
                        2'd1:    scl_nx    = 1'b1;
                        default: sda_oe_nx = 1'b1;
                     endcase
                  end
               end else begin
                  case (ph_s)
                     2'd0: begin
                        scl_nx    = 1'b0;
                        sda_oe_nx = tx_en_s && !slot_s[3] && !tx_bit_s;
                     end
                     2'd1: scl_nx = 1'b1;
                     2'd2: begin
                        ack_smp_s = tx_en_s && slot_s[3];
                        rx_smp_s  = !tx_en_s && !slot_s[3];
                     end
                     default: scl_nx = 1'b0;
                  endcase
                  if (byte_last_s) begin
                     cnt_nx      = 6'd0;
                     rx_commit_s = (state_r == ST_DATA_RD);
                     case (state_r)
                        ST_SLADDR:  state_nx = bit_ctrl_r ? ST_ADDR16 : ST_ADDR8;
                        ST_ADDR16:  state_nx = ST_ADDR8;
                        ST_ADDR8:   state_nx = rh_wl_r ? ST_ADDR_RD : ST_DATA_WR;
                        ST_ADDR_RD: state_nx = ST_DATA_RD;
                        default:    state_nx = ST_STOP;
                     endcase
                  end else begin
                     cnt_nx = cnt_r + 6'd1;
                  end
               end
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // FSM state register and registered bus pins / done pulse
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 6'd0;
         scl_r    <= 1'b1;
         sda_oe_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nx;
         cnt_r    <= cnt_nx;
         scl_r    <= scl_nx;
         sda_oe_r <= sda_oe_nx;
         done_r   <= done_nx;
      end
   end

   // Command capture, acknowledge status and received data
   always_ff @(posedge clk) begin
      if (rst_n) begin
         pend_r     <= 1'b0;
         bit_ctrl_r <= 1'b0;
         addr_r     <= 16'h0000;
         wdata_r    <= 8'h00;
         rh_wl_r    <= 1'b0;
         ack_r      <= 1'b0;
         rx_sh_r    <= 8'h00;
         data_r_r   <= 8'h00;
      end else begin
         if (accept_s) begin
            pend_r     <= 1'b0;
            bit_ctrl_r <= bit_ctrl;
            addr_r     <= i2c_addr;
            wdata_r    <= i2c_data_w;
            rh_wl_r    <= i2c_rh_wl;
         end else if (i2c_exec && (state_r == ST_IDLE)) begin
            pend_r <= 1'b1;
         end else begin
            pend_r <= pend_r;
         end
         if (accept_s) begin
            ack_r <= 1'b0;
         end else if (ack_smp_s && (sda == 1'b1)) begin
            ack_r <= 1'b1;                 // sticky NACK flag
         end else begin
            ack_r <= ack_r;
         end
         if (rx_smp_s) begin
            rx_sh_r <= {rx_sh_r[6:0], sda};
         end else begin
            rx_sh_r <= rx_sh_r;
         end
         if (rx_commit_s) begin
            data_r_r <= rx_sh_r;
         end else begin
            data_r_r <= data_r_r;
         end
      end
   end

endmodule

// File: tb/tb_i2c_driver.sv
// Bench for i2c_driver: a bus-level EEPROM slave/monitor decodes START,
// STOP and bytes from scl/sda and compares them to byte lists derived
// from the command fields.
`timescale 1ns/1ps
module tb_i2c_driver;

   localparam logic [6:0] SLV = 7'b1010000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_ctrl;
   logic [15:0] i2c_addr;
   logic [7:0]  i2c_data_w;
   logic        i2c_exec;
   logic        i2c_rh_wl;
   wire         dri_clk;
   wire         scl;
   wire         i2c_ack;
   wire  [7:0]  i2c_data_r;
   wire         i2c_done;
   wire         sda;

   logic        slave_drv = 1'b0;
   logic        slave_present = 1'b1;
   logic [7:0]  slave_rdata = 8'h00;

   pullup (sda);
   assign sda = slave_drv ? 1'b0 : 1'bz;

   always #10 clk = ~clk;

   i2c_driver dut (
      .clk(clk), .rst_n(rst_n), .bit_ctrl(bit_ctrl), .i2c_addr(i2c_addr),
      .i2c_data_w(i2c_data_w), .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl),
      .dri_clk(dri_clk), .scl(scl), .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r),
      .i2c_done(i2c_done), .sda(sda)
   );

   // monitor / slave state
   logic        prev_scl = 1'b1, prev_sda = 1'b1;
   int          bitcnt = 0;
   logic [7:0]  shreg = 8'h00;
   logic        first_b = 1'b0, rd_mode = 1'b0, slave_tx = 1'b0;
   logic [7:0]  log_q[$];
   int          n_start = 0, n_stop = 0, n_done = 0, n_nine_hi = 0;
   int          n_period = 0, bad_period = 0;
   time         last_rise = 0;

   int          n_checks = 0, n_err = 0;
   logic [7:0]  model_dr = 8'h00;

   // Bus monitor and EEPROM slave, sampled on the falling clk edge
   always @(negedge clk) begin
      logic c, s;
      c = scl;
      s = sda;
      if (i2c_done === 1'b1) n_done++;
      if (rst_n === 1'b1) begin
         slave_drv = 1'b0; bitcnt = 0; slave_tx = 1'b0; rd_mode = 1'b0; first_b = 1'b0;
      end else if (prev_scl && c && prev_sda && !s) begin
         n_start++; bitcnt = 0; first_b = 1'b1; rd_mode = 1'b0; slave_tx = 1'b0; slave_drv = 1'b0;
      end else if (prev_scl && c && !prev_sda && s) begin
         n_stop++; bitcnt = 0; slave_tx = 1'b0; slave_drv = 1'b0;
      end else if (!prev_scl && c) begin
         if (bitcnt >= 1 && bitcnt <= 8) begin
            n_period++;
            if ($time - last_rise != 64'd4000) bad_period++;
         end
         last_rise = $time;
         if (bitcnt < 8) begin
            shreg = {shreg[6:0], s};
            bitcnt++;
         end else begin
            if (slave_tx && s) n_nine_hi++;
            bitcnt = 9;
         end
      end else if (prev_scl && !c) begin
         if (bitcnt == 8) begin
            log_q.push_back(shreg);
            if (!slave_tx) begin
               if (first_b) begin
                  rd_mode = shreg[0];
                  first_b = 1'b0;
               end
               slave_drv = slave_present;
            end else begin
               slave_drv = 1'b0;
            end
         end else if (bitcnt == 9) begin
            bitcnt = 0;
            if (rd_mode && !slave_tx) begin
               slave_tx  = 1'b1;
               slave_drv = slave_present & ~slave_rdata[7];
            end else begin
               slave_tx  = 1'b0;
               slave_drv = 1'b0;
            end
         end else if (slave_tx && bitcnt >= 1 && bitcnt <= 7) begin
            slave_drv = slave_present & ~slave_rdata[7 - bitcnt];
         end
      end
      prev_scl = c;
      prev_sda = s;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One command, checked against the byte list the command must produce
   task automatic run_cmd(input logic rw, input logic bc, input logic [15:0] addr,
                          input logic [7:0] wd, input logic present, input logic [7:0] rd);
      logic [7:0] exp_q[$];
      logic [7:0] exp_dr;
      int base, s0, p0, d0, nh0, np0, bp0, cyc;
      slave_present = present;
      slave_rdata   = rd;
      exp_q.push_back({SLV, 1'b0});
      if (bc) exp_q.push_back(addr[15:8]);
      exp_q.push_back(addr[7:0]);
      if (rw) begin
         exp_q.push_back({SLV, 1'b1});
         exp_q.push_back(present ? rd : 8'hFF);
         exp_dr = present ? rd : 8'hFF;
      end else begin
         exp_q.push_back(wd);
         exp_dr = model_dr;
      end
      base = log_q.size(); s0 = n_start; p0 = n_stop; d0 = n_done;
      nh0 = n_nine_hi; np0 = n_period; bp0 = bad_period;
      @(negedge clk);
      bit_ctrl = bc; i2c_addr = addr; i2c_data_w = wd; i2c_rh_wl = rw; i2c_exec = 1'b1;
      @(negedge clk);
      i2c_exec = 1'b0;
      repeat (60) @(negedge clk);
      check("ack_cleared", 32'(i2c_ack), 32'd0);
      repeat (500) @(negedge clk);
      i2c_exec = 1'b1;                      // must be ignored while busy
      @(negedge clk);
      i2c_exec = 1'b0;
      cyc = 0;
      while (n_done == d0 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 32'(n_done != d0), 32'd1);
      repeat (300) @(negedge clk);
      check("done_pulses", 32'(n_done - d0), 32'd1);
      check("byte_count", 32'(log_q.size() - base), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (base + k < log_q.size())
            check($sformatf("byte%0d", k), 32'(log_q[base + k]), 32'(exp_q[k]));
      end
      check("starts", 32'(n_start - s0), rw ? 32'd2 : 32'd1);
      check("stops", 32'(n_stop - p0), 32'd1);
      check("master_nack", 32'(n_nine_hi - nh0), rw ? 32'd1 : 32'd0);
      check("i2c_ack", 32'(i2c_ack), present ? 32'd0 : 32'd1);
      check("i2c_data_r", 32'(i2c_data_r), 32'(exp_dr));
      check("scl_period_seen", 32'(n_period > np0), 32'd1);
      check("scl_period_bad", 32'(bad_period - bp0), 32'd0);
      check("idle_scl", 32'(scl), 32'd1);
      check("idle_sda", 32'(sda), 32'd1);
      model_dr = exp_dr;
   endtask

   initial begin
      time rises[$];
      time falls[$];
      logic pd;
      int bad_idle;
      rst_n = 1'b1; bit_ctrl = 1'b0; i2c_addr = 16'h0000; i2c_data_w = 8'h00;
      i2c_exec = 1'b0; i2c_rh_wl = 1'b0;
      #201;
      @(negedge clk);
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_dri_clk", 32'(dri_clk), 32'd0);
      check("rst_ack", 32'(i2c_ack), 32'd0);
      check("rst_data_r", 32'(i2c_data_r), 32'd0);
      check("rst_done", 32'(i2c_done), 32'd0);
      rst_n = 1'b0;

      // idle run with no command: dri_clk timing, bus stays released
      slave_present = 1'b0;
      bad_idle = 0;
      pd = dri_clk;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (dri_clk && !pd) rises.push_back($time);
         if (!dri_clk && pd) falls.push_back($time);
         pd = dri_clk;
         if (scl !== 1'b1 || sda !== 1'b1 || i2c_done !== 1'b0) bad_idle++;
      end
      check("dri_rise_count", 32'(rises.size() >= 3), 32'd1);
      if (rises.size() >= 2) check("dri_period", 32'(rises[1] - rises[0]), 32'd1000);
      if (rises.size() >= 1 && falls.size() >= 2)
         check("dri_high", 32'(((falls[0] > rises[0]) ? falls[0] : falls[1]) - rises[0]), 32'd500);
      check("idle_bus", 32'(bad_idle), 32'd0);
      check("idle_starts", 32'(n_start), 32'd0);
      check("idle_done", 32'(n_done), 32'd0);
      check("idle_ack", 32'(i2c_ack), 32'd0);
      check("idle_data_r", 32'(i2c_data_r), 32'd0);

      run_cmd(1'b0, 1'b0, 16'h0012, 8'hA5, 1'b1, 8'h00);
      run_cmd(1'b0, 1'b1, 16'h1234, 8'h3C, 1'b1, 8'h00);
      run_cmd(1'b1, 1'b1, 16'h0100, 8'h00, 1'b1, 8'h5A);
      run_cmd(1'b0, 1'b0, 16'h0077, 8'h11, 1'b0, 8'h00);   // no slave: NACKs
      run_cmd(1'b0, 1'b0, 16'h0033, 8'h22, 1'b1, 8'h00);   // clears sticky ack

      // reset in the middle of the first byte
      begin
         int d0;
         slave_present = 1'b1;
         d0 = n_done;
         @(negedge clk);
         bit_ctrl = 1'b0; i2c_addr = 16'h0044; i2c_data_w = 8'h99; i2c_rh_wl = 1'b0; i2c_exec = 1'b1;
         @(negedge clk);
         i2c_exec = 1'b0;
         repeat (700) @(negedge clk);
         check("pre_rst_busy", 32'(n_start > 0), 32'd1);
         rst_n = 1'b1;
         @(negedge clk);
         check("midrst_scl", 32'(scl), 32'd1);
         check("midrst_sda", 32'(sda), 32'd1);
         check("midrst_data_r", 32'(i2c_data_r), 32'd0);
         repeat (3) @(negedge clk);
         rst_n = 1'b0;
         repeat (400) @(negedge clk);
         check("midrst_no_done", 32'(n_done - d0), 32'd0);
         check("midrst_idle_scl", 32'(scl), 32'd1);
         model_dr = 8'h00;
      end

      for (int r = 0; r < 3; r++) begin
         run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                 8'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
